// File: rtl/rv32i_host_pkg.sv
// Shared definitions for the RV32I host controller: FSM encoding,
// default ABI register indices and a counter-width helper.
package rv32i_host_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } host_state_e;

  localparam int REG_A0 = 10;
  localparam int REG_T6 = 31;

  // One spare bit so the terminal count always fits.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/rv32i_host_wdog.sv
// RUN-phase watchdog: counts enabled cycles and flags the last allowed one.
module rv32i_host_wdog
  import rv32i_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int              CW   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Cycle counter: cleared outside RUN, advances once per RUN cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  // Expiry is combinational so the FSM can leave RUN in the same cycle.
  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/rv32i_host_ctrl.sv
// Host-side controller for an RV32I core: holds the core, injects the
// operands into consecutive registers, releases the core and snoops its
// register-file writes for the result and a completion flag.
module rv32i_host_ctrl
  import rv32i_host_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int N_ARGS         = 2,
  parameter int ARG_BASE_REG   = REG_A0,
  parameter int RESULT_REG     = REG_A0,
  parameter int DONE_REG       = REG_T6,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_calc_start,
  input  logic [N_ARGS*XLEN-1:0] i_args,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_timeout,
  output logic [XLEN-1:0]        o_result,
  output logic                   o_core_hold,
  output logic                   o_inj_we,
  output logic [4:0]             o_inj_addr,
  output logic [XLEN-1:0]        o_inj_data,
  input  logic                   i_core_we,
  input  logic [4:0]             i_core_waddr,
  input  logic [XLEN-1:0]        i_core_wdata
);

  if (N_ARGS < 1 || N_ARGS > 8 || ARG_BASE_REG + N_ARGS - 1 > 31 ||
      ARG_BASE_REG < 1 || RESULT_REG < 1 || RESULT_REG > 31 ||
      DONE_REG < 1 || DONE_REG > 31 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("rv32i_host_ctrl: illegal register map or operand count");
  end

  localparam int                IDX_W    = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ARGS - 1);
  localparam logic [4:0]        BASE     = 5'(ARG_BASE_REG);
  localparam logic [4:0]        RES_IDX  = 5'(RESULT_REG);
  localparam logic [4:0]        DONE_IDX = 5'(DONE_REG);

  host_state_e            r_state, w_next;
  logic [IDX_W-1:0]       r_idx;
  logic [N_ARGS*XLEN-1:0] r_args;
  logic [XLEN-1:0]        r_shadow;
  logic [XLEN-1:0]        r_result;
  logic                   r_timeout;

  logic                   w_run, w_cap, w_fin, w_expire;
  logic [XLEN-1:0]        w_arg [N_ARGS];

  for (genvar g = 0; g < N_ARGS; g++) begin : g_arg
    assign w_arg[g] = r_args[g*XLEN +: XLEN];
  end

  // Snoop decode; only meaningful while the core is released.
  assign w_run = (r_state == RUN);
  assign w_cap = w_run && i_core_we && (i_core_waddr == RES_IDX) && (i_core_waddr != 5'd0);
  assign w_fin = w_run && i_core_we && (i_core_waddr == DONE_IDX) && (i_core_wdata != '0);

  rv32i_host_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (!w_run),
    .i_en     (w_run),
    .o_expire (w_expire)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and state-decoded outputs; hold drops only in RUN so the
  // core can never execute while operands are still being injected.
  always_comb begin
    w_next      = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_core_hold = 1'b1;
    o_inj_we    = 1'b0;
    o_inj_addr  = 5'd0;
    o_inj_data  = '0;
    case (r_state)
      IDLE: if (i_calc_start) w_next = LOAD;
      LOAD: begin
        o_busy     = 1'b1;
        o_inj_we   = 1'b1;
        o_inj_addr = BASE + 5'(r_idx);
        o_inj_data = w_arg[r_idx];
        if (r_idx == LAST_IDX) w_next = RUN;
      end
      RUN: begin
        o_busy      = 1'b1;
        o_core_hold = 1'b0;
        // A completion in the expiry cycle still counts as success.
        if (w_fin)         w_next = DONE;
        else if (w_expire) w_next = ERR;
      end
      DONE: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand latch, injection index, result shadow and flags.
  // The result is loaded on the RUN->DONE edge so it is valid with done;
  // when result and done share a register the in-flight write is used.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx     <= '0;
      r_args    <= '0;
      r_shadow  <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_calc_start) begin
          r_args    <= i_args;
          r_shadow  <= '0;
          r_timeout <= 1'b0;
          r_idx     <= '0;
        end
        LOAD: r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        RUN: begin
          if (w_cap) r_shadow <= i_core_wdata;
          if (w_fin)         r_result  <= w_cap ? i_core_wdata : r_shadow;
          else if (w_expire) r_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_result  = r_result;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_rv32i_host_ctrl.sv
// Bench for rv32i_host_ctrl: two instances (2 operands / 16-cycle watchdog
// and 3 operands / 40-cycle watchdog) share stimulus; a stub core plays a
// per-RUN-cycle write schedule and an outcome model predicts the result.
module tb_rv32i_host_ctrl;
  localparam int XLEN = 32;
  localparam int MAXR = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        start;
  logic [3*XLEN-1:0] args;
  logic              cwe;
  logic [4:0]        cwa;
  logic [31:0]       cwd;

  logic        busy [2], done [2], tmo [2], hold [2], iwe [2];
  logic [31:0] res [2], idata [2];
  logic [4:0]  iaddr [2];

  int tos   [2] = '{16, 40};
  int nargs [2] = '{2, 3};

  rv32i_host_ctrl #(.N_ARGS(2), .TIMEOUT_CYCLES(16)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_calc_start(start[0]), .i_args(args[2*XLEN-1:0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_timeout(tmo[0]), .o_result(res[0]),
    .o_core_hold(hold[0]), .o_inj_we(iwe[0]), .o_inj_addr(iaddr[0]), .o_inj_data(idata[0]),
    .i_core_we(cwe), .i_core_waddr(cwa), .i_core_wdata(cwd));

  rv32i_host_ctrl #(.N_ARGS(3), .TIMEOUT_CYCLES(40)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_calc_start(start[1]), .i_args(args),
    .o_busy(busy[1]), .o_done(done[1]), .o_timeout(tmo[1]), .o_result(res[1]),
    .o_core_hold(hold[1]), .o_inj_we(iwe[1]), .o_inj_addr(iaddr[1]), .o_inj_data(idata[1]),
    .i_core_we(cwe), .i_core_waddr(cwa), .i_core_wdata(cwd));

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_res [2];

  // Stub-core write schedule, indexed by RUN cycle.
  bit          wwe [MAXR];
  logic [4:0]  wa  [MAXR];
  logic [31:0] wd  [MAXR];
  int          ign_cyc;
  int          rst_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sched();
    for (int k = 0; k < MAXR; k++) begin
      wwe[k] = 1'b0; wa[k] = 5'd0; wd[k] = 32'd0;
    end
    ign_cyc = -1;
    rst_cyc = -1;
  endtask

  task automatic add_w(input int k, input logic [4:0] a, input logic [31:0] d);
    wwe[k] = 1'b1; wa[k] = a; wd[k] = d;
  endtask

  // Outcome model: walk the schedule; the first nonzero x31 write ends the
  // run with the most recent x10 value, otherwise the watchdog expires.
  function automatic void model(input int sel, output int rcyc, output bit fin,
                                output logic [31:0] nres);
    logic [31:0] sh;
    sh   = 32'd0;
    rcyc = tos[sel];
    fin  = 1'b0;
    nres = exp_res[sel];
    for (int k = 0; k < tos[sel]; k++) begin
      if (wwe[k] && wa[k] == 5'd10) sh = wd[k];
      if (wwe[k] && wa[k] == 5'd31 && wd[k] != 0) begin
        fin = 1'b1; rcyc = k + 1; nres = sh;
        break;
      end
    end
  endfunction

  task automatic check_rst(input int sel);
    chk("rst_busy",  busy[sel],  0);
    chk("rst_done",  done[sel],  0);
    chk("rst_tmo",   tmo[sel],   0);
    chk("rst_res",   res[sel],   0);
    chk("rst_hold",  hold[sel],  1);
    chk("rst_iwe",   iwe[sel],   0);
    chk("rst_iaddr", iaddr[sel], 0);
    chk("rst_idata", idata[sel], 0);
  endtask

  // One start-to-idle transaction on instance sel. sdone pulses a start in
  // the DONE/ERR cycle, which must not be accepted.
  task automatic run(input int sel, input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] a2, input bit sdone);
    int          n;
    int          rc;
    bit          fin;
    logic [31:0] nres;
    logic [31:0] av [3];
    n  = nargs[sel];
    av = '{a0, a1, a2};
    model(sel, rc, fin, nres);
    @(negedge clk);
    chk("idle_busy", busy[sel], 0);
    chk("idle_hold", hold[sel], 1);
    args = {a2, a1, a0};
    start[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    args = {$urandom, $urandom, $urandom};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("load_we",   iwe[sel],   1);
      chk("load_addr", iaddr[sel], 10 + i);
      chk("load_data", idata[sel], av[i]);
      chk("load_hold", hold[sel],  1);
      chk("load_busy", busy[sel],  1);
      if (i == 0) chk("start_clr_tmo", tmo[sel], 0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < rc; k++) begin
      cwe = wwe[k]; cwa = wa[k]; cwd = wd[k];
      if (k == ign_cyc) begin
        start[sel] = 1'b1;
        args = {$urandom, $urandom, $urandom};
      end
      if (k == rst_cyc) begin
        rst = 1'b1;
        #1;
        check_rst(sel);
        exp_res[0] = 32'd0;
        exp_res[1] = 32'd0;
        #2;
        rst = 1'b0;
        cwe = 1'b0;
        return;
      end
      @(negedge clk);
      chk("run_hold", hold[sel], 0);
      chk("run_busy", busy[sel], 1);
      chk("run_done", done[sel], 0);
      chk("run_iwe",  iwe[sel],  0);
      @(posedge clk); #1;
      start[sel] = 1'b0;
      cwe = 1'b0;
    end
    if (sdone) start[sel] = 1'b1;
    @(negedge clk);
    chk("end_hold", hold[sel], 1);
    chk("end_busy", busy[sel], 0);
    if (fin) begin
      chk("done_pulse", done[sel], 1);
      chk("done_tmo",   tmo[sel],  0);
      chk("done_res",   res[sel],  nres);
      exp_res[sel] = nres;
    end else begin
      chk("err_done", done[sel], 0);
      chk("err_tmo",  tmo[sel],  1);
      chk("err_res",  res[sel],  exp_res[sel]);
    end
    @(posedge clk); #1;
    start[sel] = 1'b0;
    @(negedge clk);
    chk("post_done", done[sel], 0);
    chk("post_busy", busy[sel], 0);
    chk("post_tmo",  tmo[sel],  fin ? 0 : 1);
    @(negedge clk);
    chk("post_busy2", busy[sel], 0);
  endtask

  initial begin
    int          s;
    logic [4:0]  a;
    logic [31:0] d;
    start = 2'b00; args = '0; cwe = 1'b0; cwa = 5'd0; cwd = 32'd0;
    exp_res[0] = 32'd0;
    exp_res[1] = 32'd0;
    clear_sched();
    #3;
    check_rst(0);
    check_rst(1);
    @(negedge clk);
    rst = 1'b0;

    // Normal GCD(48,18).
    clear_sched(); add_w(2, 10, 6); add_w(4, 31, 1);
    run(0, 48, 18, 0, 1'b0);
    // Three operands.
    clear_sched(); add_w(3, 10, 105); add_w(5, 31, 1);
    run(1, 7, 5, 3, 1'b1);
    // Timeout: result must keep 6 despite a late x10 write.
    clear_sched(); add_w(3, 10, 99);
    run(0, 11, 22, 0, 1'b0);
    // Ignored start during RUN, zero completion, then a real one.
    clear_sched(); ign_cyc = 1; add_w(2, 31, 0); add_w(3, 10, 77); add_w(6, 31, 5);
    run(0, 30, 40, 0, 1'b1);
    // Completion on the final allowed RUN cycle.
    clear_sched(); add_w(10, 10, 32'h1234); add_w(15, 31, 1);
    run(0, 5, 6, 0, 1'b0);
    // Reset mid-RUN, then a clean run.
    clear_sched(); rst_cyc = 5; add_w(7, 10, 1); add_w(8, 31, 1);
    run(0, 48, 18, 0, 1'b0);
    clear_sched(); add_w(2, 10, 6); add_w(4, 31, 1);
    run(0, 48, 18, 0, 1'b0);

    // Randomised schedules on both instances.
    for (int t = 0; t < 20; t++) begin
      s = int'($urandom % 2);
      clear_sched();
      for (int k = 0; k < tos[s]; k++) begin
        if ($urandom % 4 == 0) begin
          case ($urandom % 4)
            0:       a = 5'd10;
            1:       a = 5'd31;
            2:       a = 5'($urandom);
            default: a = 5'd0;
          endcase
          d = (a == 5'd31 && ($urandom % 2) == 0) ? 32'd0 : $urandom;
          add_w(k, a, d);
        end
      end
      run(s, $urandom, $urandom, $urandom, 1'($urandom % 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_host_ctrl.md
Name: rv32i_host_ctrl

Overview:
- Parametrised host-side controller that replaces the hard-wired two-operand GCD start/result path.
- Holds the RV32I core in PC reset while idle and latches N_ARGS operands on a start pulse.
- Writes the operands into consecutive architectural registers, then releases the core and snoops its register-file write port for result and completion writes.
- Returns the result with a done pulse, or raises a timeout. Sits between the SoC host pins and the core top.

Parameters:
- XLEN, 32, datapath and register width.
- N_ARGS, 2, operand count (1..8).
- ARG_BASE_REG, 10, register index that receives arg0; argi goes to ARG_BASE_REG+i.
- RESULT_REG, 10, register whose last write before completion is the result.
- DONE_REG, 31, a nonzero write to this register signals completion.
- TIMEOUT_CYCLES, 65535, maximum RUN cycles before abort (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- calc_start  in  1  single-cycle start request
- args  in  N_ARGS*XLEN  operands; argi is bits [i*XLEN +: XLEN]
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse on normal completion
- timeout  out  1  sticky abort flag
- result  out  XLEN  registered result
- core_hold  out  1  high keeps the core PC at reset vector
- inj_we  out  1  operand injection write enable to reg file
- inj_addr  out  5  injection register index
- inj_data  out  XLEN  injection data
- core_we  in  1  snooped core rd write enable
- core_waddr  in  5  snooped rd index
- core_wdata  in  XLEN  snooped rd data

Behaviour:
- Reset values (asynchronous, rst=1): state IDLE, busy 0, done 0, timeout 0, result 0, core_hold 1, inj_we 0, inj_addr 0, inj_data 0, arg index 0, timeout counter 0, result shadow 0.
- IDLE:
  - core_hold=1.
  - calc_start=1 latches all args, clears timeout and the shadow, and moves to LOAD on the next edge.
- LOAD:
  - One operand per cycle: inj_we=1, inj_addr=ARG_BASE_REG+idx, inj_data=arg[idx], with idx 0..N_ARGS-1.
  - After the write of idx N_ARGS-1, go to RUN.
  - LOAD lasts exactly N_ARGS cycles; core_hold stays 1.
- RUN:
  - core_hold=0; the counter increments every cycle.
  - core_we && core_waddr==RESULT_REG && core_waddr!=0 captures core_wdata into the shadow.
  - core_we && core_waddr==DONE_REG && core_wdata!=0 goes to DONE.
  - If RESULT_REG==DONE_REG, the same write both captures and completes.
  - If the counter reaches TIMEOUT_CYCLES-1 without completion, go to ERR.
  - A completion write in the same cycle as counter expiry wins: go to DONE.
- DONE (1 cycle): result<=shadow, done=1, core_hold=1, then IDLE.
- ERR (1 cycle): timeout<=1, result unchanged, core_hold=1, then IDLE.
- busy=1 in LOAD and RUN only.
- calc_start outside IDLE is ignored, with no re-latch.
- A calc_start arriving in the same cycle that DONE or ERR returns to IDLE is ignored; only a start sampled while in IDLE is accepted.
- Start-to-done latency is N_ARGS + (RUN cycles) + 1.
- core_hold rises combinationally with the state, so the core never runs during LOAD.
- Injection addresses are computed modulo 32. A configuration where ARG_BASE_REG+N_ARGS-1 > 31, or where any of the base, result or done indices is 0, is rejected by an elaboration check.
- Counter width is clog2(TIMEOUT_CYCLES)+1.
- rst asserted mid-operation returns everything to reset values immediately. The core is held; no done pulse and no timeout are produced.

Decomposition:
- Shared package rv32i_host_pkg:
  - state encoding constants IDLE=0, LOAD=1, RUN=2, DONE=3, ERR=4 (3 bits);
  - default register index constants REG_A0=10, REG_T6=31.
- One natural sub-module, rv32i_host_wdog: the timeout counter with clear, enable and expire outputs, parametrised by TIMEOUT_CYCLES.

Test Plan:
- Reset mid-RUN: with N_ARGS=2, start args=(48,18); assert rst in cycle 5 of RUN -> all outputs at reset values the same cycle and core_hold=1. A subsequent clean start completes normally.
- Normal GCD: start with args=(48,18); stub core writes x10=6 then x31=1 -> inj writes x10=48 then x11=18 on consecutive cycles, then one done pulse with result=6 and busy low the next cycle.
- Three operands: N_ARGS=3, args=(7,5,3); stub writes x10=105 then x31=1 -> inj_addr sequence 10,11,12, result=105, latency = 3+RUN+1.
- Timeout: TIMEOUT_CYCLES=16; stub never writes x31 -> timeout=1 after 16 RUN cycles, done stays 0, result keeps the previous value 6. The next start clears timeout.
- Ignored start and zero done: pulse calc_start during RUN -> no re-latch. A write of x31=0 -> no completion. A later x31=5 -> done.
- Tie case: completion write on the final RUN cycle (counter=TIMEOUT_CYCLES-1) -> done=1 and timeout=0.
